shift_74164_loader: RTL and testbench

SHIFT_74164_LOADER -- requirements
Module: shift_74164_loader

---
 rtl/shift_74164_pkg.sv | 30 +++
 rtl/half_period_timer.sv | 38 +++
 rtl/shift_74164_loader.sv | 135 +++++++++++++
 tb/tb_shift_74164_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_74164_pkg.sv
// Shared constants, state encoding and pin bundle for the 74164 serial loader.
package shift_74164_pkg;

    localparam int unsigned HALF_DEFAULT = 1;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned BIT_W        = 3;
    localparam int unsigned BYTE_W       = 8;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOW   = 2'd2,
        ST_HIGH  = 2'd3
    } state_t;

    // Pins driven toward the downstream 74164.
    typedef struct packed {
        logic dsa;
        logic dsb;
        logic cp;
        logic n_mr;
    } sr_pins_t;

    localparam sr_pins_t SR_PINS_RESET = '{dsa: 1'b0, dsb: 1'b1, cp: 1'b0, n_mr: 1'b0};

    function automatic logic [CNT_W-1:0] half_reload(input int unsigned half);
        return CNT_W'(half - 1);
    endfunction

endpackage

// File: rtl/half_period_timer.sv
// Reloadable half-period down-counter; tick is high in the last cycle of a phase.
module half_period_timer
    import shift_74164_pkg::*;
#(
    parameter int unsigned HALF = HALF_DEFAULT
) (
    input  logic cp,
    input  logic mr,
    input  logic reload,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = half_reload(HALF);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // tick is registered from the next count so it lines up with cnt_q == 0.
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            cnt_q <= RELOAD;
            tick  <= (RELOAD == '0);
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/shift_74164_loader.sv
// Serialises a byte MSB-first into a 74164, generating its shift clock and clear.
module shift_74164_loader
    import shift_74164_pkg::*;
#(
    parameter int unsigned HALF = HALF_DEFAULT
) (
    input  logic       cp,
    input  logic       mr,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    input  logic       clr,
    output logic       done,
    output logic       sr_dsa,
    output logic       sr_dsb,
    output logic       sr_cp,
    output logic       sr_n_mr
);

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                phase_q, phase_d;
    sr_pins_t            pins_q, pins_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                tick;
    logic                reload;

    // Every state entry happens on a tick or out of IDLE, so reloading there suffices.
    assign reload = tick || (state_q == ST_IDLE);

    half_period_timer #(.HALF(HALF)) u_timer (
        .cp     (cp),
        .mr     (mr),
        .reload (reload),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        pins_d      = pins_q;
        pins_d.dsb  = 1'b1;
        done_d      = 1'b0;

        case (state_q)
            // CLEAR spans two timer phases, tracked by phase_q.
            ST_CLEAR: begin
                pins_d.cp   = 1'b0;
                pins_d.n_mr = 1'b0;
                if (tick) begin
                    if (phase_q) begin
                        state_d     = ST_IDLE;
                        pins_d.n_mr = 1'b1;
                        phase_d     = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                pins_d.cp   = 1'b0;
                pins_d.n_mr = 1'b1;
                if (clr) begin
                    state_d     = ST_CLEAR;
                    pins_d.n_mr = 1'b0;
                    phase_d     = 1'b0;
                end else if (valid) begin
                    state_d    = ST_LOW;
                    shift_d    = data;
                    pins_d.dsa = data[7];
                    bit_d      = '0;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    state_d   = ST_HIGH;
                    pins_d.cp = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    pins_d.cp = 1'b0;
                    if (bit_q == BIT_W'(BYTE_W - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_LOW;
                        shift_d    = {shift_q[BYTE_W-2:0], 1'b0};
                        pins_d.dsa = shift_q[BYTE_W-2];
                        bit_d      = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                pins_d  = SR_PINS_RESET;
                phase_d = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            state_q <= ST_CLEAR;
            shift_q <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            pins_q  <= SR_PINS_RESET;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            pins_q  <= pins_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign sr_dsa  = pins_q.dsa;
    assign sr_dsb  = pins_q.dsb;
    assign sr_cp   = pins_q.cp;
    assign sr_n_mr = pins_q.n_mr;

endmodule

// File: tb/tb_shift_74164_loader.sv
// Bench: two loaders (HALF=1 and HALF=2), each driving a behavioural 74164.
module tb_shift_74164_loader;

    logic       cp;
    logic       mr;
    logic [7:0] data [2];
    logic [1:0] valid;
    logic [1:0] clr;
    logic [1:0] ready;
    logic [1:0] done;
    logic [1:0] sr_dsa;
    logic [1:0] sr_dsb;
    logic [1:0] sr_cp;
    logic [1:0] sr_n_mr;

    logic [7:0]  q0, q1;
    int unsigned cyc;
    int          edges0, edges1;
    int          hi_run1, bad_hi1;
    int          checks, failures;

    typedef struct {
        logic [7:0]  b;
        int unsigned due;
    } exp_t;

    exp_t sb0 [$];
    exp_t sb1 [$];
    int   e_base [2];

    shift_74164_loader #(.HALF(1)) u_h1 (
        .cp(cp), .mr(mr), .data(data[0]), .valid(valid[0]), .ready(ready[0]),
        .clr(clr[0]), .done(done[0]), .sr_dsa(sr_dsa[0]), .sr_dsb(sr_dsb[0]),
        .sr_cp(sr_cp[0]), .sr_n_mr(sr_n_mr[0])
    );

    shift_74164_loader #(.HALF(2)) u_h2 (
        .cp(cp), .mr(mr), .data(data[1]), .valid(valid[1]), .ready(ready[1]),
        .clr(clr[1]), .done(done[1]), .sr_dsa(sr_dsa[1]), .sr_dsb(sr_dsb[1]),
        .sr_cp(sr_cp[1]), .sr_n_mr(sr_n_mr[1])
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    always @(posedge cp) cyc <= cyc + 1;

    // Behavioural 74164 parts hanging off each loader.
    always @(posedge sr_cp[0] or negedge sr_n_mr[0]) begin
        if (!sr_n_mr[0]) q0 <= 8'h00;
        else             q0 <= {q0[6:0], sr_dsa[0] & sr_dsb[0]};
    end
    always @(posedge sr_cp[1] or negedge sr_n_mr[1]) begin
        if (!sr_n_mr[1]) q1 <= 8'h00;
        else             q1 <= {q1[6:0], sr_dsa[1] & sr_dsb[1]};
    end

    always @(posedge sr_cp[0]) edges0 <= edges0 + 1;
    always @(posedge sr_cp[1]) edges1 <= edges1 + 1;

    // Each HALF=2 shift-clock high phase must last exactly 2 cycles.
    always @(negedge cp) begin
        if (sr_cp[1]) begin
            hi_run1 <= hi_run1 + 1;
        end else begin
            if (hi_run1 != 0 && hi_run1 != 2) bad_hi1 <= bad_hi1 + 1;
            hi_run1 <= 0;
        end
    end

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int edges_of(input int i);
        return (i == 0) ? edges0 : edges1;
    endfunction

    function automatic logic [7:0] q_of(input int i);
        return (i == 0) ? q0 : q1;
    endfunction

    function automatic int unsigned half_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic push_exp(input int i, input logic [7:0] b);
        exp_t e;
        e.b   = b;
        e.due = cyc + 16 * half_of(i);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        e_base[i] = edges_of(i);
    endtask

    // Offer a byte and return just after the accept edge.
    task automatic load(input int i, input logic [7:0] b);
        int n;
        n = 0;
        while (!ready[i] && n < 100) begin
            step();
            n++;
        end
        if (!ready[i]) check("ready_timeout", 32'(ready[i]), 1);
        data[i]  = b;
        valid[i] = 1'b1;
        step();
        push_exp(i, b);
        valid[i] = 1'b0;
    endtask

    // Wait for done, then compare against the oldest scoreboard entry.
    task automatic wait_done(input int i, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!done[i] && n < int'(16 * half_of(i) + 8)) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done[i]), 1);
        check({tag, "_ready_with_done"}, 32'(ready[i]), 1);
        if (i == 0) begin
            check({tag, "_sb_nonempty"}, 32'(sb0.size() != 0), 1);
            if (sb0.size() != 0) e = sb0.pop_front();
        end else begin
            check({tag, "_sb_nonempty"}, 32'(sb1.size() != 0), 1);
            if (sb1.size() != 0) e = sb1.pop_front();
        end
        check({tag, "_cycle"}, cyc, e.due);
        check({tag, "_q"}, 32'(q_of(i)), 32'(e.b));
        check({tag, "_edges"}, 32'(edges_of(i) - e_base[i]), 8);
    endtask

    initial begin
        int n;
        int bad_base;
        logic done_any;

        checks   = 0;
        failures = 0;
        mr       = 1'b0;
        valid    = '0;
        clr      = '0;
        data[0]  = '0;
        data[1]  = '0;
        #1 mr = 1'b1;
        repeat (3) step();

        check("rst_ready", 32'(ready[0]), 0);
        check("rst_done", 32'(done[0]), 0);
        check("rst_n_mr", 32'(sr_n_mr[0]), 0);
        check("rst_cp", 32'(sr_cp[0]), 0);
        check("rst_dsa", 32'(sr_dsa[0]), 0);
        check("rst_dsb", 32'(sr_dsb[0]), 1);
        check("rst_q", 32'(q0), 0);

        mr = 1'b0;
        #1 check("rel_c1_n_mr", 32'(sr_n_mr[0]), 0);
        step();
        check("rel_c2_n_mr", 32'(sr_n_mr[0]), 0);
        check("rel_c2_ready", 32'(ready[0]), 0);
        step();
        check("rel_c3_ready", 32'(ready[0]), 1);
        check("rel_c3_n_mr", 32'(sr_n_mr[0]), 1);
        check("rel_q", 32'(q0), 0);
        check("rel_h2_c3_ready", 32'(ready[1]), 0);
        step();
        check("rel_h2_c4_ready", 32'(ready[1]), 0);
        step();
        check("rel_h2_c5_ready", 32'(ready[1]), 1);

        // Single byte at HALF=1.
        load(0, 8'hA5);
        wait_done(0, "a5");
        step();
        check("a5_done_pulse", 32'(done[0]), 0);

        // Back-to-back at HALF=2 with valid held high.
        bad_base = bad_hi1;
        data[1]  = 8'hA5;
        valid[1] = 1'b1;
        step();
        push_exp(1, 8'hA5);
        data[1] = 8'h3C;
        wait_done(1, "b2b_a5");
        step();
        push_exp(1, 8'h3C);
        valid[1] = 1'b0;
        check("b2b_done_pulse", 32'(done[1]), 0);
        check("b2b_busy", 32'(ready[1]), 0);
        wait_done(1, "b2b_3c");
        check("b2b_hi_width", 32'(bad_hi1 - bad_base), 0);
        step();

        // clr and valid together: clear wins, byte taken on the next ready.
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        clr[0]   = 1'b1;
        step();
        clr[0] = 1'b0;
        check("clr_ready", 32'(ready[0]), 0);
        check("clr_n_mr", 32'(sr_n_mr[0]), 0);
        check("clr_cp", 32'(sr_cp[0]), 0);
        check("clr_q", 32'(q0), 0);
        n        = 0;
        done_any = 1'b0;
        while (!ready[0] && n < 10) begin
            step();
            done_any |= done[0];
            n++;
        end
        check("clr_len", 32'(n), 2);
        check("clr_no_done", 32'(done_any), 0);
        check("clr_n_mr_back", 32'(sr_n_mr[0]), 1);
        step();
        push_exp(0, 8'hFF);
        valid[0] = 1'b0;
        wait_done(0, "ff");
        step();

        // Requests while busy are dropped.
        load(0, 8'h81);
        for (int k = 0; k < 12; k++) begin
            valid[0] = (k == 2) || (k == 8);
            clr[0]   = (k == 5) || (k == 8);
            data[0]  = 8'h55;
            step();
        end
        valid[0] = 1'b0;
        clr[0]   = 1'b0;
        wait_done(0, "x81");
        check("x81_n_mr", 32'(sr_n_mr[0]), 1);
        repeat (3) step();
        check("x81_idle_ready", 32'(ready[0]), 1);
        check("x81_no_requeue", 32'(edges0 - e_base[0]), 8);
        check("x81_q_hold", 32'(q0), 32'h81);

        // Reset in the middle of a load.
        load(0, 8'hF0);
        n = 0;
        while ((edges0 - e_base[0]) < 3 && n < 40) begin
            step();
            n++;
        end
        check("abort_edges", 32'(edges0 - e_base[0]), 3);
        #1 mr = 1'b1;
        #1;
        check("abort_cp_low", 32'(sr_cp[0]), 0);
        check("abort_done", 32'(done[0]), 0);
        check("abort_ready", 32'(ready[0]), 0);
        done_any = 1'b0;
        repeat (2) begin
            step();
            done_any |= done[0];
        end
        mr = 1'b0;
        sb0.delete();
        n = 0;
        while (!ready[0] && n < 10) begin
            step();
            done_any |= done[0];
            n++;
        end
        check("abort_no_done", 32'(done_any), 0);
        check("abort_ready_back", 32'(ready[0]), 1);
        check("abort_q", 32'(q0), 0);
        check("abort_edges_frozen", 32'(edges0 - e_base[0]), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
